// File: rtl/hamming_secded_stream_corrector.sv
// Two-stage valid/ready Hamming SEC / SECDED stream corrector with saturating error statistics.
// Block bit i carries Hamming position i+1; with SECDED the MSB is the overall even-parity bit.
module hamming_secded_stream_corrector #(
  parameter int  BLOCK_WIDTH   = 32'sd15,
  parameter int  SECDED        = 32'sd1,
  parameter int  COUNTER_WIDTH = 32'sd8,
  localparam int PARITY_WIDTH  = $clog2(BLOCK_WIDTH + 32'sd1),
  localparam int DATA_WIDTH    = BLOCK_WIDTH - PARITY_WIDTH,
  localparam int IN_WIDTH      = BLOCK_WIDTH + SECDED
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_WIDTH-1:0]      in_block,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [PARITY_WIDTH-1:0]  out_syndrome,
  output logic                     out_corrected,
  output logic                     out_uncorrectable,
  input  logic                     clear_counters,
  output logic [COUNTER_WIDTH-1:0] corrected_count,
  output logic [COUNTER_WIDTH-1:0] uncorrectable_count
);

  // Hamming position (1-based) of data bit d: the d-th position that is not a power of two.
  function automatic int data_pos(input int d);
    int cnt;
    int res;
    cnt = 32'sd0;
    res = 32'sd0;
    for (int pos = 32'sd1; pos <= BLOCK_WIDTH; pos++) begin
      if ((pos & (pos - 32'sd1)) != 32'sd0) begin
        if (cnt == d) begin
          res = pos;
        end
        cnt++;
      end
    end
    return res;
  endfunction

  // Data positions checked by parity bit k (positions whose index has bit k set).
  function automatic logic [BLOCK_WIDTH-1:0] cover_mask(input int k);
    logic [BLOCK_WIDTH-1:0] m;
    m = '0;
    for (int pos = 32'sd1; pos <= BLOCK_WIDTH; pos++) begin
      if (((pos & (pos - 32'sd1)) != 32'sd0) && (((pos >> k) & 32'sd1) != 32'sd0)) begin
        m = m | (BLOCK_WIDTH'(1'b1) << (pos - 32'sd1));
      end
    end
    return m;
  endfunction

  // Even parity over the masked bits of a block.
  function automatic logic masked_parity(input logic [BLOCK_WIDTH-1:0] blk,
                                         input logic [BLOCK_WIDTH-1:0] mask);
    return ^(blk & mask);
  endfunction

  // Overall parity mismatch of the extended block (zero in plain SEC mode).
  function automatic logic overall_mismatch(input logic [IN_WIDTH-1:0] blk);
    return (SECDED != 32'sd0) ? (^blk) : 1'b0;
  endfunction

  logic                    s2_advance_s;
  logic                    s1_advance_s;
  logic                    in_accept_s;
  logic                    out_accept_s;
  logic                    ready_en_r;
  logic [DATA_WIDTH-1:0]   unpacked_s;
  logic [PARITY_WIDTH-1:0] syndrome_s;
  logic                    s1_valid_r;
  logic [DATA_WIDTH-1:0]   s1_data_r;
  logic [PARITY_WIDTH-1:0] s1_syndrome_r;
  logic                    s1_pmis_r;
  logic [DATA_WIDTH-1:0]   flip_pos_s;
  logic                    syn_nz_s;
  logic                    in_range_s;
  logic                    corr_s;
  logic                    unc_s;
  logic                    flip_en_s;
  logic [DATA_WIDTH-1:0]   fixed_data_s;

  assign s2_advance_s = !out_valid || out_ready;
  assign s1_advance_s = !s1_valid_r || s2_advance_s;
  assign in_ready     = ready_en_r && !reset && s1_advance_s;
  assign in_accept_s  = in_valid && in_ready;
  assign out_accept_s = out_valid && out_ready;

  for (genvar d = 32'sd0; d < DATA_WIDTH; d++) begin : g_unpack
    localparam int DPOS = data_pos(d);
    assign unpacked_s[d] = in_block[DPOS - 32'sd1];
    // Data bit d sits at the position the syndrome names when that bit flipped.
    assign flip_pos_s[d] = (s1_syndrome_r == PARITY_WIDTH'(DPOS));
  end

  for (genvar k = 32'sd0; k < PARITY_WIDTH; k++) begin : g_syndrome
    localparam int PPOS = (32'sd1 << k) - 32'sd1;
    assign syndrome_s[k] = in_block[PPOS] ^ masked_parity(in_block[BLOCK_WIDTH-1:0], cover_mask(k));
  end

  assign syn_nz_s   = |s1_syndrome_r;
  assign in_range_s = (s1_syndrome_r <= PARITY_WIDTH'(BLOCK_WIDTH));

  // Classify the stage-1 result and build the corrected data word.
  always_comb begin
    corr_s    = 1'b0;
    unc_s     = 1'b0;
    flip_en_s = 1'b0;
    if (SECDED != 32'sd0) begin
      if (!syn_nz_s) begin
        corr_s = s1_pmis_r;          // only the overall parity bit itself was hit
      end else if (!s1_pmis_r) begin
        unc_s = 1'b1;                // even number of flips: double error
      end else if (in_range_s) begin
        corr_s    = 1'b1;
        flip_en_s = 1'b1;
      end else begin
        unc_s = 1'b1;                // syndrome points past a shortened block
      end
    end else begin
      if (!syn_nz_s) begin
        corr_s = 1'b0;
      end else if (in_range_s) begin
        corr_s    = 1'b1;
        flip_en_s = 1'b1;
      end else begin
        unc_s = 1'b1;
      end
    end
    if (flip_en_s) begin
      fixed_data_s = s1_data_r ^ flip_pos_s;
    end else begin
      fixed_data_s = s1_data_r;
    end
  end

  // Stage 1: register unpacked data, syndrome and overall parity mismatch.
  always_ff @(posedge clock) begin
    if (reset) begin
      ready_en_r    <= 1'b0;
      s1_valid_r    <= 1'b0;
      s1_data_r     <= '0;
      s1_syndrome_r <= '0;
      s1_pmis_r     <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
      if (s1_advance_s) begin
        s1_valid_r    <= in_accept_s;
        s1_data_r     <= unpacked_s;
        s1_syndrome_r <= syndrome_s;
        s1_pmis_r     <= overall_mismatch(in_block);
      end else begin
        s1_valid_r <= s1_valid_r;
      end
    end
  end

  // Stage 2: register the corrected result; hold it while the consumer stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_syndrome      <= '0;
      out_corrected     <= 1'b0;
      out_uncorrectable <= 1'b0;
    end else if (s2_advance_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_data          <= fixed_data_s;
        out_syndrome      <= s1_syndrome_r;
        out_corrected     <= corr_s;
        out_uncorrectable <= unc_s;
      end else begin
        out_data <= out_data;
      end
    end else begin
      out_valid <= out_valid;
    end
  end

  // Saturating error statistics, counted on output handshakes; clear has priority.
  always_ff @(posedge clock) begin
    if (reset || clear_counters) begin
      corrected_count     <= '0;
      uncorrectable_count <= '0;
    end else begin
      if (out_accept_s && out_corrected && (corrected_count != '1)) begin
        corrected_count <= corrected_count + COUNTER_WIDTH'(1'b1);
      end else begin
        corrected_count <= corrected_count;
      end
      if (out_accept_s && out_uncorrectable && (uncorrectable_count != '1)) begin
        uncorrectable_count <= uncorrectable_count + COUNTER_WIDTH'(1'b1);
      end else begin
        uncorrectable_count <= uncorrectable_count;
      end
    end
  end

endmodule

// File: tb/tb_hamming_secded_stream_corrector.sv
// Bench for hamming_secded_stream_corrector: three configurations, a position-arithmetic
// reference model with a scoreboard, and directed vectors with hand-computed results.
module tb_hamming_secded_stream_corrector;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  syn;
    logic        cor;
    logic        unc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rst_prev = 1'b0;
  logic        iv  [3];
  logic        orr [3];
  logic        clr [3];
  logic [15:0] ib  [3];

  logic        ir [3];
  logic        ov [3];
  logic        oc [3];
  logic        ou [3];
  logic [15:0] od [3];
  logic [3:0]  os [3];
  logic [7:0]  cc [3];
  logic [7:0]  uc [3];

  wire       ir0, ov0, oc0, ou0, ir1, ov1, oc1, ou1, ir2, ov2, oc2, ou2;
  wire [3:0] od0, od1;
  wire [2:0] od2, os0, os1, os2;
  wire [7:0] cc0, uc0, cc2, uc2;
  wire [1:0] cc1, uc1;

  int bw_c   [3] = '{7, 7, 6};
  int sec_c  [3] = '{1, 1, 0};
  int cmax_c [3] = '{255, 3, 255};

  int   total = 0;
  int   bad   = 0;
  exp_t sb [3][$];
  int   exp_cc [3];
  int   exp_uc [3];
  logic held [3];
  exp_t held_v [3];

  // SECDED, 7-bit block, 8-bit counters
  hamming_secded_stream_corrector #(.BLOCK_WIDTH(7), .SECDED(1), .COUNTER_WIDTH(8)) u_dut0 (
    .clock(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir0), .in_block(ib[0][7:0]),
    .out_valid(ov0), .out_ready(orr[0]), .out_data(od0), .out_syndrome(os0),
    .out_corrected(oc0), .out_uncorrectable(ou0), .clear_counters(clr[0]),
    .corrected_count(cc0), .uncorrectable_count(uc0));

  // SECDED, 7-bit block, 2-bit counters
  hamming_secded_stream_corrector #(.BLOCK_WIDTH(7), .SECDED(1), .COUNTER_WIDTH(2)) u_dut1 (
    .clock(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir1), .in_block(ib[1][7:0]),
    .out_valid(ov1), .out_ready(orr[1]), .out_data(od1), .out_syndrome(os1),
    .out_corrected(oc1), .out_uncorrectable(ou1), .clear_counters(clr[1]),
    .corrected_count(cc1), .uncorrectable_count(uc1));

  // plain SEC, shortened 6-bit block
  hamming_secded_stream_corrector #(.BLOCK_WIDTH(6), .SECDED(0), .COUNTER_WIDTH(8)) u_dut2 (
    .clock(clk), .reset(rst), .in_valid(iv[2]), .in_ready(ir2), .in_block(ib[2][5:0]),
    .out_valid(ov2), .out_ready(orr[2]), .out_data(od2), .out_syndrome(os2),
    .out_corrected(oc2), .out_uncorrectable(ou2), .clear_counters(clr[2]),
    .corrected_count(cc2), .uncorrectable_count(uc2));

  assign ir[0] = ir0; assign ov[0] = ov0; assign oc[0] = oc0; assign ou[0] = ou0;
  assign ir[1] = ir1; assign ov[1] = ov1; assign oc[1] = oc1; assign ou[1] = ou1;
  assign ir[2] = ir2; assign ov[2] = ov2; assign oc[2] = oc2; assign ou[2] = ou2;
  assign od[0] = {12'd0, od0}; assign od[1] = {12'd0, od1}; assign od[2] = {13'd0, od2};
  assign os[0] = {1'b0, os0};  assign os[1] = {1'b0, os1};  assign os[2] = {1'b0, os2};
  assign cc[0] = cc0; assign uc[0] = uc0;
  assign cc[1] = {6'd0, cc1}; assign uc[1] = {6'd0, uc1};
  assign cc[2] = cc2; assign uc[2] = uc2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: syndrome is the XOR of the positions of all set bits, overall parity is the
  // XOR of the whole extended block; fix the named position, then drop power-of-two positions.
  function automatic exp_t model(input logic [15:0] blk, input int bw, input int sec);
    exp_t        e;
    int          s;
    int          d;
    logic        pm;
    logic [15:0] fixed;
    s = 0;
    for (int p = 1; p <= bw; p++) if (blk[p-1]) s = s ^ p;
    pm = 1'b0;
    if (sec != 0) for (int p = 0; p <= bw; p++) pm = pm ^ blk[p];
    e = '0;
    fixed = blk;
    if (s == 0 && !pm) begin
      e.cor = 1'b0;
    end else if (sec != 0 && s == 0) begin
      e.cor = 1'b1;
    end else if (sec != 0 && !pm) begin
      e.unc = 1'b1;
    end else if (s <= bw) begin
      e.cor = 1'b1;
      fixed[s-1] = ~fixed[s-1];
    end else begin
      e.unc = 1'b1;
    end
    d = 0;
    for (int p = 1; p <= bw; p++) begin
      if ((p & (p - 1)) != 0) begin
        e.data[d] = fixed[p-1];
        d++;
      end
    end
    e.syn = 4'(s);
    return e;
  endfunction

  // Per-cycle comparison of every instance against the scoreboard and counter model.
  always @(negedge clk) begin
    exp_t cur;
    for (int i = 0; i < 3; i++) begin
      cur.data = od[i]; cur.syn = os[i]; cur.cor = oc[i]; cur.unc = ou[i];
      if (rst) begin
        chk("rst_in_ready", ir[i], 0);
        if (rst_prev) begin
          chk("rst_out_valid", ov[i], 0);
          chk("rst_outputs", cur, 0);
          chk("rst_corrected_count", cc[i], 0);
          chk("rst_uncorrectable_count", uc[i], 0);
        end
        sb[i].delete();
        exp_cc[i] = 0;
        exp_uc[i] = 0;
        held[i] = 1'b0;
      end else begin
        chk("corrected_count", cc[i], exp_cc[i]);
        chk("uncorrectable_count", uc[i], exp_uc[i]);
        if (held[i]) begin
          chk("stall_valid_hold", ov[i], 1);
          chk("stall_outputs_hold", cur, held_v[i]);
        end
        if (ov[i]) begin
          if (sb[i].size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            chk("output_vs_model", cur, sb[i][0]);
            if (orr[i]) begin
              if (sb[i][0].cor && exp_cc[i] < cmax_c[i]) exp_cc[i]++;
              if (sb[i][0].unc && exp_uc[i] < cmax_c[i]) exp_uc[i]++;
              void'(sb[i].pop_front());
            end
          end
        end
        if (clr[i]) begin
          exp_cc[i] = 0;
          exp_uc[i] = 0;
        end
        held[i]   = ov[i] && !orr[i];
        held_v[i] = cur;
        if (iv[i] && ir[i]) sb[i].push_back(model(ib[i], bw_c[i], sec_c[i]));
      end
    end
    rst_prev = rst;
  end

  // One block with the consumer ready; checks exact latency and hand-computed results.
  task automatic send_pin(input int i, input logic [15:0] blk, input logic [15:0] d,
                          input logic [3:0] s, input logic c, input logic u, input string tag);
    ib[i] = blk; iv[i] = 1'b1; orr[i] = 1'b1;
    #1;
    chk({tag, "_in_ready"}, ir[i], 1);
    @(posedge clk); #1;
    iv[i] = 1'b0;
    chk({tag, "_not_valid_after_1"}, ov[i], 0);
    @(posedge clk); #1;
    chk({tag, "_valid_after_2"}, ov[i], 1);
    chk({tag, "_data"}, od[i], d);
    chk({tag, "_syndrome"}, os[i], s);
    chk({tag, "_corrected"}, oc[i], c);
    chk({tag, "_uncorrectable"}, ou[i], u);
  endtask

  logic [15:0] stream [3] = '{16'h0055, 16'h0045, 16'h0056};

  initial begin
    int   idx;
    logic saw_drop;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; orr[i] = 1'b1; clr[i] = 1'b0; ib[i] = 16'h0000;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("reset_out_valid", ov[i], 0);
      chk("reset_in_ready_low", ir[i], 0);
      chk("reset_counts", {cc[i], uc[i]}, 0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) chk("in_ready_after_reset", ir[i], 1);

    // SECDED 7-bit block: clean, single data error, parity-bit error, double error
    send_pin(0, 16'h0055, 16'hB, 4'd0, 1'b0, 1'b0, "clean_55");
    send_pin(0, 16'h0045, 16'hB, 4'd5, 1'b1, 1'b0, "single_45");
    send_pin(0, 16'h00D5, 16'hB, 4'd0, 1'b1, 1'b0, "pbit_D5");
    send_pin(0, 16'h0056, 16'hB, 4'd3, 1'b0, 1'b1, "double_56");
    @(posedge clk); #1;
    chk("pins_corrected_count", cc[0], 2);
    chk("pins_uncorrectable_count", uc[0], 1);

    // back-to-back stream with the consumer stalled on cycles 3-5
    idx = 0;
    saw_drop = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      orr[0] = !(cyc >= 3 && cyc <= 5);
      if (idx < 3) begin
        iv[0] = 1'b1; ib[0] = stream[idx];
      end else begin
        iv[0] = 1'b0;
      end
      #1;
      if (!ir[0]) saw_drop = 1'b1;
      if (iv[0] && ir[0]) idx++;
      @(posedge clk); #1;
    end
    iv[0] = 1'b0; orr[0] = 1'b1;
    chk("stall_in_ready_dropped", saw_drop, 1);
    chk("stall_all_accepted", idx, 3);
    chk("stall_corrected_count", cc[0], 3);
    chk("stall_uncorrectable_count", uc[0], 2);

    // 2-bit counters: saturation, then clear against a simultaneous increment
    ib[1] = 16'h0045; iv[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    iv[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("sat_corrected_count", cc[1], 3);
    clr[1] = 1'b1;
    @(posedge clk); #1;
    clr[1] = 1'b0;
    chk("clear_alone", cc[1], 0);
    send_pin(1, 16'h0045, 16'hB, 4'd5, 1'b1, 1'b0, "cw2_single");
    @(posedge clk); #1;
    chk("after_one_corrected", cc[1], 1);
    send_pin(1, 16'h0045, 16'hB, 4'd5, 1'b1, 1'b0, "cw2_single_b");
    clr[1] = 1'b1;
    @(posedge clk); #1;
    clr[1] = 1'b0;
    chk("clear_beats_increment", cc[1], 0);

    // plain SEC, shortened 6-bit block
    send_pin(2, 16'h0034, 16'h7, 4'd0, 1'b0, 1'b0, "sec_clean");
    send_pin(2, 16'h0014, 16'h7, 4'd6, 1'b1, 1'b0, "sec_single");
    send_pin(2, 16'h000C, 16'h1, 4'd7, 1'b0, 1'b1, "sec_out_of_range");
    @(posedge clk); #1;
    chk("sec_corrected_count", cc[2], 1);
    chk("sec_uncorrectable_count", uc[2], 1);

    // reset with two blocks in flight
    orr[0] = 1'b0; ib[0] = 16'h0045; iv[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chk("inflight_out_valid", ov[0], 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset_out_valid", ov[0], 0);
    chk("midreset_corrected_count", cc[0], 0);
    chk("midreset_uncorrectable_count", uc[0], 0);
    chk("midreset_in_ready", ir[0], 0);
    rst = 1'b0; orr[0] = 1'b1;
    @(posedge clk); #1;
    chk("postreset_in_ready", ir[0], 1);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("scoreboard_drained", sb[i].size(), 0);
      chk("idle_out_valid", ov[i], 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
